// File: rtl/axi_mem_slave_if.sv
// AXI4 write/read channel bundle between a master and axi_mem_slave.
// Carries AW, W, B, AR and R channels; lock/cache/prot/qos/user are not carried.
// The master modport drives VALIDs and payloads; the slave drives READYs and responses.
interface axi_mem_slave_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     S_AXI_AWID;
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [7:0]              S_AXI_AWLEN;
  logic [2:0]              S_AXI_AWSIZE;
  logic [1:0]              S_AXI_AWBURST;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WLAST;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [ID_WIDTH-1:0]     S_AXI_BID;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ID_WIDTH-1:0]     S_AXI_ARID;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [7:0]              S_AXI_ARLEN;
  logic [2:0]              S_AXI_ARSIZE;
  logic [1:0]              S_AXI_ARBURST;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [ID_WIDTH-1:0]     S_AXI_RID;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RLAST;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder backed by a word array; INCR/FIXED bursts, WRAP answered with SLVERR.
// Latency: AW/AR accepted the cycle after idle, B and first R beat one cycle after last W / AR.
// Backpressure: one beat per cycle; optional LFSR gating under AXI_MEM_BACKPRESSURE_EN.
module axi_mem_slave #(
  parameter int    DATA_WIDTH     = 64,
  parameter int    ADDR_WIDTH     = 32,
  parameter int    ID_WIDTH       = 1,
  parameter int    MEM_DEPTH_LOG2 = 10,
  parameter string INIT_FILE      = ""
) (
  input logic            ACLK,
  input logic            ARESETN,
  axi_mem_slave_if.slave s_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = $clog2(STRB_WIDTH);
  localparam int DEPTH      = 1 << MEM_DEPTH_LOG2;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents start as zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  idx_t                  aw_idx, ar_idx;
  assign aw_addr = s_axi.S_AXI_AWADDR;
  assign ar_addr = s_axi.S_AXI_ARADDR;
  assign aw_idx  = aw_addr[OFFS +: MEM_DEPTH_LOG2];
  assign ar_idx  = ar_addr[OFFS +: MEM_DEPTH_LOG2];

  // Transfer size is ignored: every beat is full width.
  logic unused_bits;
  assign unused_bits = &{1'b0, s_axi.S_AXI_AWSIZE, s_axi.S_AXI_ARSIZE, aw_addr, ar_addr};

  logic ready_en, gate, b_hold, r_hold;

  // Readies stay low through reset and rise on the first edge after release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr;
  // Free-running LFSR; cycles with lfsr[1:0]==0 suppress readies and new valids.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign gate = (lfsr[1:0] != 2'b00);

  // Remember an already-raised VALID so the gate can never withdraw it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      b_hold <= 1'b0;
      r_hold <= 1'b0;
    end else begin
      b_hold <= s_axi.S_AXI_BVALID & ~s_axi.S_AXI_BREADY;
      r_hold <= s_axi.S_AXI_RVALID & ~s_axi.S_AXI_RREADY;
    end
  end
`else
  assign gate   = 1'b1;
  assign b_hold = 1'b0;
  assign r_hold = 1'b0;
`endif

  // ---------------- write channel ----------------
  wstate_t             w_state, w_next;
  logic [ID_WIDTH-1:0] w_id;
  idx_t                w_idx;
  logic [7:0]          w_len, w_cnt;
  logic [1:0]          w_burst;
  logic                w_err, aw_hs, w_hs, b_hs, w_final;

  assign aw_hs   = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
  assign w_hs    = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
  assign b_hs    = s_axi.S_AXI_BVALID & s_axi.S_AXI_BREADY;
  assign w_final = (w_cnt == w_len);

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write FSM transitions: burst length comes from AWLEN, never from WLAST.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_final) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write channel outputs decoded from state and latched burst fields.
  always_comb begin
    s_axi.S_AXI_AWREADY = (w_state == W_IDLE) & ready_en & gate;
    s_axi.S_AXI_WREADY  = (w_state == W_DATA) & gate;
    s_axi.S_AXI_BVALID  = (w_state == W_RESP) & (gate | b_hold);
    s_axi.S_AXI_BID     = w_id;
    s_axi.S_AXI_BRESP   = ((w_state == W_RESP) && (w_err || w_burst == BURST_WRAP)) ?
                          RESP_SLVERR : RESP_OKAY;
  end

  // Latch the AW fields, then walk index and beat count; flag misplaced WLAST.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s_axi.S_AXI_AWID;
      w_idx   <= aw_idx;
      w_len   <= s_axi.S_AXI_AWLEN;
      w_burst <= s_axi.S_AXI_AWBURST;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (w_burst != BURST_FIXED) w_idx <= w_idx + idx_t'(1);
      if (s_axi.S_AXI_WLAST != w_final) w_err <= 1'b1;
    end
  end

  // Byte-enabled array write; WRAP bursts are drained without touching memory.
  always @(posedge ACLK) begin
    if (w_hs && w_burst != BURST_WRAP) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (s_axi.S_AXI_WSTRB[b]) mem[w_idx][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  idx_t                  r_idx, r_next_idx;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ar_hs, r_hs, r_final;

  assign ar_hs      = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
  assign r_hs       = s_axi.S_AXI_RVALID & s_axi.S_AXI_RREADY;
  assign r_final    = (r_cnt == r_len);
  assign r_next_idx = (r_burst == BURST_FIXED) ? r_idx : r_idx + idx_t'(1);

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read FSM transitions.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_final) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read channel outputs; payload is registered so it holds while stalled.
  always_comb begin
    s_axi.S_AXI_ARREADY = (r_state == R_IDLE) & ready_en & gate;
    s_axi.S_AXI_RVALID  = (r_state == R_DATA) & (gate | r_hold);
    s_axi.S_AXI_RID     = r_id;
    s_axi.S_AXI_RDATA   = rdata;
    s_axi.S_AXI_RLAST   = (r_state == R_DATA) & r_final;
    s_axi.S_AXI_RRESP   = ((r_state == R_DATA) && r_burst == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
  end

  // Prefetch each beat into rdata; a same-cycle write to that word is not seen.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      rdata   <= '0;
    end else if (ar_hs) begin
      r_id    <= s_axi.S_AXI_ARID;
      r_idx   <= ar_idx;
      r_len   <= s_axi.S_AXI_ARLEN;
      r_burst <= s_axi.S_AXI_ARBURST;
      r_cnt   <= '0;
      rdata   <= mem[ar_idx];
    end else if (r_hs && !r_final) begin
      r_idx <= r_next_idx;
      r_cnt <= r_cnt + 8'd1;
      rdata <= mem[r_next_idx];
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: directed scenarios plus randomized bursts.
// Expected data comes from a word-array model updated with AXI burst rules.
// Inputs driven at negedge / just after posedge; outputs sampled at negedge.
module tb_axi_mem_slave;
  localparam int DW = 64, AW = 32, IW = 1, DL2 = 10, DEPTH = 1 << DL2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_mem_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH_LOG2(DL2), .INIT_FILE("")
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] wr_data[$];
  logic [7:0]  wr_strb[$];
  logic [63:0] rd_data[$];
  logic        rd_last[$];
  logic [1:0]  rd_resp[$];
  logic [0:0]  rd_id[$];

  // ---------------- reference model ----------------
  function automatic int beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    int base;
    base = int'((addr >> 3) % DEPTH);
    return (burst == 2'b00) ? base : (base + beat) % DEPTH;
  endfunction

  function automatic void model_apply(input logic [31:0] addr, input int len, input logic [1:0] burst);
    int i;
    if (burst == 2'b10) return;
    for (int b = 0; b <= len; b++) begin
      i = beat_idx(addr, burst, b);
      for (int k = 0; k < 8; k++)
        if (wr_strb[b][k]) model[i][k*8 +: 8] = wr_data[b][k*8 +: 8];
    end
  endfunction

  // ---------------- bus drivers ----------------
  task automatic idle_bus();
    bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = 3'd3;
    bus.S_AXI_AWBURST = 2'b01; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = 3'd3;
    bus.S_AXI_ARBURST = 2'b01; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [0:0] id);
    int n = 0;
    @(negedge clk);
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = len; bus.S_AXI_AWBURST = burst;
    bus.S_AXI_AWID = id; bus.S_AXI_AWVALID = 1'b1;
    while (!bus.S_AXI_AWREADY && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin checks++; failures++; $display("FAIL aw_timeout: got no AWREADY want AWREADY=1"); end
    @(posedge clk); #1 bus.S_AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    @(negedge clk);
    bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WLAST = last; bus.S_AXI_WVALID = 1'b1;
    while (!bus.S_AXI_WREADY && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin checks++; failures++; $display("FAIL w_timeout: got no WREADY want WREADY=1"); end
    @(posedge clk); #1 bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output logic [0:0] bid, output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.S_AXI_BVALID && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) begin checks++; failures++; $display("FAIL b_timeout: got no BVALID want BVALID=1"); end
    resp = bus.S_AXI_BRESP; bid = bus.S_AXI_BID;
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1 bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [0:0] id, input int bad_last,
                             output logic [1:0] resp, output logic [0:0] bid, output int lat);
    send_aw(addr, len, burst, id);
    for (int b = 0; b <= int'(len); b++)
      send_w(wr_data[b], wr_strb[b], (bad_last >= 0) ? (b == bad_last) : (b == int'(len)));
    wait_b(resp, bid, lat);
    model_apply(addr, int'(len), burst);
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [0:0] id);
    int n = 0;
    @(negedge clk);
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = len; bus.S_AXI_ARBURST = burst;
    bus.S_AXI_ARID = id; bus.S_AXI_ARVALID = 1'b1;
    while (!bus.S_AXI_ARREADY && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin checks++; failures++; $display("FAIL ar_timeout: got no ARREADY want ARREADY=1"); end
    @(posedge clk); #1 bus.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [0:0] id, input bit stall, output int lat);
    int got = 0, guard = 0;
    bit take;
    rd_data.delete(); rd_last.delete(); rd_resp.delete(); rd_id.delete();
    send_ar(addr, len, burst, id);
    lat = 0;
    while (got <= int'(len) && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (bus.S_AXI_RVALID) begin
        take = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.S_AXI_RREADY = take;
        if (take) begin
          rd_data.push_back(bus.S_AXI_RDATA); rd_last.push_back(bus.S_AXI_RLAST);
          rd_resp.push_back(bus.S_AXI_RRESP); rd_id.push_back(bus.S_AXI_RID);
          got++;
        end
        @(posedge clk); #1 bus.S_AXI_RREADY = 1'b0;
      end else if (got == 0) lat++;
    end
    if (guard >= 1000) begin checks++; failures++; $display("FAIL r_timeout: got %0d beats want %0d", got, int'(len) + 1); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_bus();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin failures++; $display("FAIL reset_readies: got %b want 000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
    checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RLAST} !== 3'b000) begin failures++; $display("FAIL reset_valids: got %b want 000", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RLAST}); end
    checks++; if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_BID, bus.S_AXI_RID} !== 6'd0) begin failures++; $display("FAIL reset_resp_id: got %b want 0", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_BID, bus.S_AXI_RID}); end
    checks++; if (bus.S_AXI_RDATA !== 64'd0) begin failures++; $display("FAIL reset_rdata: got %h want 0", bus.S_AXI_RDATA); end
    rst_n = 1'b1; #1;
    checks++; if (bus.S_AXI_AWREADY !== 1'b0) begin failures++; $display("FAIL release_awready_early: got %b want 0", bus.S_AXI_AWREADY); end
    @(negedge clk);
    checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 2'b11) begin failures++; $display("FAIL release_readies: got %b want 11", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}); end
  endtask

  task automatic test_incr();
    logic [1:0] resp; logic [0:0] bid; int lat;
    logic [63:0] pat;
    wr_data.delete(); wr_strb.delete();
    for (int b = 0; b < 4; b++) begin pat = {16{4'(b + 1)}}; wr_data.push_back(pat); wr_strb.push_back(8'hFF); end
    write_burst(32'h100, 8'd3, 2'b01, 1'b0, -1, resp, bid, lat);
    checks++; if (lat !== 0) begin failures++; $display("FAIL incr_b_latency: got %0d want 0", lat); end
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL incr_bresp: got %b want 00", resp); end
    read_burst(32'h100, 8'd3, 2'b01, 1'b1, 1'b0, lat);
    checks++; if (lat !== 0) begin failures++; $display("FAIL incr_r_latency: got %0d want 0", lat); end
    for (int b = 0; b < 4 && b < rd_data.size(); b++) begin
      pat = {16{4'(b + 1)}};
      checks++; if (rd_data[b] !== pat) begin failures++; $display("FAIL incr_rdata[%0d]: got %h want %h", b, rd_data[b], pat); end
      checks++; if (rd_last[b] !== (b == 3)) begin failures++; $display("FAIL incr_rlast[%0d]: got %b want %b", b, rd_last[b], b == 3); end
      checks++; if (rd_id[b] !== 1'b1 || rd_resp[b] !== 2'b00) begin failures++; $display("FAIL incr_rid_rresp[%0d]: got %b/%b want 1/00", b, rd_id[b], rd_resp[b]); end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [0:0] bid; int lat;
    wr_data = '{64'hFFFF_FFFF_FFFF_FFFF}; wr_strb = '{8'hFF};
    write_burst(32'h200, 8'd0, 2'b01, 1'b0, -1, resp, bid, lat);
    wr_data = '{64'h0000_0000_AABB_CCDD}; wr_strb = '{8'h0F};
    write_burst(32'h200, 8'd0, 2'b01, 1'b0, -1, resp, bid, lat);
    read_burst(32'h200, 8'd0, 2'b01, 1'b0, 1'b0, lat);
    checks++; if (rd_data.size() < 1 || rd_data[0] !== 64'hFFFF_FFFF_AABB_CCDD) begin failures++; $display("FAIL strobe_merge: got %h want ffffffffaabbccdd", rd_data.size() ? rd_data[0] : 64'hx); end
  endtask

  task automatic test_fixed();
    logic [1:0] resp; logic [0:0] bid; int lat;
    wr_data = '{64'd1, 64'd2, 64'd3, 64'd4}; wr_strb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    write_burst(32'h300, 8'd3, 2'b00, 1'b0, -1, resp, bid, lat);
    checks++; if (resp !== 2'b00) begin failures++; $display("FAIL fixed_bresp: got %b want 00", resp); end
    read_burst(32'h300, 8'd0, 2'b01, 1'b0, 1'b0, lat);
    checks++; if (rd_data.size() < 1 || rd_data[0] !== 64'd4) begin failures++; $display("FAIL fixed_last_wins: got %h want 4", rd_data.size() ? rd_data[0] : 64'hx); end
    read_burst(32'h308, 8'd1, 2'b01, 1'b0, 1'b0, lat);
    for (int b = 0; b < 2 && b < rd_data.size(); b++) begin
      checks++; if (rd_data[b] !== 64'd0) begin failures++; $display("FAIL fixed_neighbour[%0d]: got %h want 0", b, rd_data[b]); end
    end
  endtask

  task automatic test_b_hold();
    wr_data = '{64'h5555_0000_0000_0001, 64'h5555_0000_0000_0002}; wr_strb = '{8'hFF, 8'hFF};
    send_aw(32'h500, 8'd1, 2'b01, 1'b1);
    send_w(wr_data[0], 8'hFF, 1'b0);
    send_w(wr_data[1], 8'hFF, 1'b1);
    model_apply(32'h500, 1, 2'b01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_BID, bus.S_AXI_AWREADY} !== 3'b110) begin failures++; $display("FAIL bhold_cycle%0d: got bvalid/bid/awready=%b want 110", i, {bus.S_AXI_BVALID, bus.S_AXI_BID, bus.S_AXI_AWREADY}); end
    end
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1 bus.S_AXI_BREADY = 1'b0;
    @(negedge clk);
    checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_BVALID} !== 2'b10) begin failures++; $display("FAIL bhold_release: got awready/bvalid=%b want 10", {bus.S_AXI_AWREADY, bus.S_AXI_BVALID}); end
  endtask

  task automatic test_wlast_err();
    logic [1:0] resp; logic [0:0] bid; int lat;
    wr_data.delete(); wr_strb.delete();
    for (int b = 0; b < 4; b++) begin wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'hFF); end
    write_burst(32'h380, 8'd3, 2'b01, 1'b1, 1, resp, bid, lat);
    checks++; if (resp !== 2'b10 || bid !== 1'b1) begin failures++; $display("FAIL wlast_err_bresp: got %b/%b want 10/1", resp, bid); end
    read_burst(32'h380, 8'd3, 2'b01, 1'b0, 1'b0, lat);
    for (int b = 0; b < 4 && b < rd_data.size(); b++) begin
      checks++; if (rd_data[b] !== model[beat_idx(32'h380, 2'b01, b)]) begin failures++; $display("FAIL wlast_err_data[%0d]: got %h want %h", b, rd_data[b], model[beat_idx(32'h380, 2'b01, b)]); end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp; logic [0:0] bid; int lat;
    wr_data = '{64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0002}; wr_strb = '{8'hFF, 8'hFF};
    write_burst(32'h100, 8'd1, 2'b10, 1'b0, -1, resp, bid, lat);
    checks++; if (resp !== 2'b10) begin failures++; $display("FAIL wrap_bresp: got %b want 10", resp); end
    read_burst(32'h100, 8'd1, 2'b10, 1'b0, 1'b0, lat);
    for (int b = 0; b < 2 && b < rd_data.size(); b++) begin
      checks++; if (rd_data[b] !== model[beat_idx(32'h100, 2'b01, b)] || rd_resp[b] !== 2'b10) begin failures++; $display("FAIL wrap_read[%0d]: got %h/%b want %h/10", b, rd_data[b], rd_resp[b], model[beat_idx(32'h100, 2'b01, b)]); end
    end
  endtask

  task automatic test_read_stall();
    logic [63:0] hold_d; logic hold_l; logic hold_v = 1'b0;
    int got = 0, guard = 0;
    send_ar(32'h1FF0, 8'd5, 2'b01, 1'b1);
    while (got < 6 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (hold_v) begin
        checks++; if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== hold_d || bus.S_AXI_RLAST !== hold_l) begin failures++; $display("FAIL stall_stable: got %b/%h/%b want 1/%h/%b", bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RLAST, hold_d, hold_l); end
      end
      hold_v = 1'b0;
      if (bus.S_AXI_RVALID) begin
        bus.S_AXI_RREADY = ($urandom_range(0, 1) == 1);
        if (bus.S_AXI_RREADY) begin
          checks++; if (bus.S_AXI_RDATA !== model[beat_idx(32'h1FF0, 2'b01, got)] || bus.S_AXI_RLAST !== (got == 5)) begin failures++; $display("FAIL stall_beat%0d: got %h/%b want %h/%b", got, bus.S_AXI_RDATA, bus.S_AXI_RLAST, model[beat_idx(32'h1FF0, 2'b01, got)], got == 5); end
          got++;
        end else begin
          hold_v = 1'b1; hold_d = bus.S_AXI_RDATA; hold_l = bus.S_AXI_RLAST;
        end
        @(posedge clk); #1 bus.S_AXI_RREADY = 1'b0;
      end
    end
    if (guard >= 500) begin checks++; failures++; $display("FAIL stall_timeout: got %0d beats want 6", got); end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] resp; logic [0:0] bid; int lat, beats = 0, guard = 0;
    wr_data.delete(); wr_strb.delete();
    for (int b = 0; b < 8; b++) begin wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'hFF); end
    write_burst(32'h700, 8'd7, 2'b01, 1'b0, -1, resp, bid, lat);
    send_ar(32'h700, 8'd7, 2'b01, 1'b1);
    while (beats < 2 && guard < 100) begin
      @(negedge clk); guard++;
      if (bus.S_AXI_RVALID) begin bus.S_AXI_RREADY = 1'b1; beats++; @(posedge clk); #1 bus.S_AXI_RREADY = 1'b0; end
    end
    @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RLAST} !== 3'b000) begin failures++; $display("FAIL midreset_outputs: got rvalid/arready/rlast=%b want 000", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RLAST}); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (bus.S_AXI_ARREADY !== 1'b0) begin failures++; $display("FAIL midreset_arready_early: got %b want 0", bus.S_AXI_ARREADY); end
    @(negedge clk);
    checks++; if (bus.S_AXI_ARREADY !== 1'b1) begin failures++; $display("FAIL midreset_arready: got %b want 1", bus.S_AXI_ARREADY); end
    read_burst(32'h700, 8'd7, 2'b01, 1'b0, 1'b0, lat);
    for (int b = 0; b < 8 && b < rd_data.size(); b++) begin
      checks++; if (rd_data[b] !== wr_data[b]) begin failures++; $display("FAIL midreset_reread[%0d]: got %h want %h", b, rd_data[b], wr_data[b]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic [0:0] bid; int wlat, rlat;
    logic [63:0] exp_q[$];
    wr_data.delete(); wr_strb.delete();
    for (int b = 0; b < 4; b++) begin wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'($urandom)); end
    for (int b = 0; b < 4; b++) exp_q.push_back(model[beat_idx(32'h100, 2'b01, b)]);
    fork
      write_burst(32'h900, 8'd3, 2'b01, 1'b1, -1, resp, bid, wlat);
      read_burst(32'h100, 8'd3, 2'b01, 1'b0, 1'b0, rlat);
    join
    checks++; if (resp !== 2'b00 || bid !== 1'b1 || wlat !== 0) begin failures++; $display("FAIL concurrent_b: got %b/%b/%0d want 00/1/0", resp, bid, wlat); end
    for (int b = 0; b < 4 && b < rd_data.size(); b++) begin
      checks++; if (rd_data[b] !== exp_q[b]) begin failures++; $display("FAIL concurrent_r[%0d]: got %h want %h", b, rd_data[b], exp_q[b]); end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, burst; logic [0:0] bid; int lat, len;
    logic [31:0] addr;
    for (int it = 0; it < 30; it++) begin
      addr  = $urandom_range(0, 32'h3FFF) & 32'hFFFF_FFF8;
      len   = $urandom_range(0, 7);
      burst = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      wr_data.delete(); wr_strb.delete();
      for (int b = 0; b <= len; b++) begin wr_data.push_back({$urandom, $urandom}); wr_strb.push_back(8'($urandom)); end
      write_burst(addr, 8'(len), burst, 1'(it), -1, resp, bid, lat);
      checks++; if (resp !== ((burst == 2'b10) ? 2'b10 : 2'b00) || bid !== 1'(it)) begin failures++; $display("FAIL rand%0d_b: got %b/%b want %b/%b", it, resp, bid, (burst == 2'b10) ? 2'b10 : 2'b00, 1'(it)); end
      read_burst(addr, 8'(len), burst, 1'(it + 1), 1'b1, lat);
      for (int b = 0; b <= len && b < rd_data.size(); b++) begin
        checks++; if (rd_data[b] !== model[beat_idx(addr, (burst == 2'b00) ? 2'b00 : 2'b01, b)] || rd_last[b] !== (b == len)) begin failures++; $display("FAIL rand%0d_r[%0d]: got %h/%b want %h/%b", it, b, rd_data[b], rd_last[b], model[beat_idx(addr, (burst == 2'b00) ? 2'b00 : 2'b01, b)], b == len); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;
    test_reset();
    test_incr();
    test_strobe();
    test_fixed();
    test_b_hold();
    test_wlast_err();
    test_wrap();
    test_read_stall();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
